// File: rtl/fft_output_reorder_pkg.sv
// fft_output_reorder_pkg: shared FFT reorder types and helpers.
// Index permute, bank-state encoding and frame-length helpers.
package fft_output_reorder_pkg;

  localparam int MAXW = 16;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_DRAINING
  } bank_st_e;

  function automatic int fft_n(input int msb);
    return 1 << msb;
  endfunction

  function automatic int stg_w(input int msb);
    return (msb / 2 < 4) ? 4 : msb / 2;
  endfunction

  // Reverse the top s of msb index bits; lower bits pass through.
  function automatic logic [MAXW-1:0] fft_permute(
    input logic [MAXW-1:0] k,
    input int              s,
    input int              msb
  );
    logic [MAXW-1:0] r;
    logic [3:0]      src;
    r = k;
    for (int i = 0; i < MAXW; i++) begin
      src = 4'(2 * msb - s - 1 - i);
      if (i < msb && i >= msb - s)
        r[i] = k[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_output_reorder_if.sv
// fft_output_reorder_if: sample-in / sample-out handshakes
// of the FFT output reorder buffer.
interface fft_output_reorder_if #(
  parameter int MSB    = 8,
  parameter int DATA_W = 32
) ();
  import fft_output_reorder_pkg::*;

  localparam int STG_W = stg_w(MSB);

  logic [STG_W-1:0]  stage;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [MSB-1:0]    out_index;
  logic              out_last;

  modport master (
    output stage, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_index, out_last
  );

  modport slave (
    input  stage, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_index, out_last
  );

endinterface

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM, one write port and
// one synchronous read port with a single cycle of latency.
module fft_reorder_ram
  import fft_output_reorder_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [fft_n(AW)];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    if (i_re)
      o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/fft_output_reorder.sv
// fft_output_reorder: undoes the stage bit-reversal, emits natural order.
// FFT_REORDER_PINGPONG_EN selects two overlapping banks, else one.
module fft_output_reorder
  import fft_output_reorder_pkg::*;
#(
  parameter int MSB    = 8,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  fft_output_reorder_if.slave bus
);

`ifdef FFT_REORDER_PINGPONG_EN
  localparam int NB = 2;
  localparam int AW = MSB + 1;
`else
  localparam int NB = 1;
  localparam int AW = MSB;
`endif
  localparam int   STG_W = stg_w(MSB);
  localparam logic TOG   = (NB > 1);

  bank_st_e          r_bst [2];
  bank_st_e          w_bst [2];
  logic [MSB-1:0]    r_k, r_j, r_ridx;
  logic [MSB-1:0]    w_wperm, w_oidx;
  logic [STG_W-1:0]  r_s, w_sc, w_s;
  logic              r_wbank, r_rbank;
  logic              r_cbank, r_rvalid;
  logic [DATA_W-1:0] r_qd [2];
  logic [MSB-1:0]    r_qi [2];
  logic              r_qr, r_qw;
  logic [1:0]        r_cnt;
  logic              w_wr, w_rd, w_rok;
  logic              w_pop, w_popq, w_push;
  logic              w_lastpop, w_recycle;
  logic              w_wfree, w_ovalid;
  logic [AW-1:0]     w_waddr, w_raddr;
  logic [DATA_W-1:0] w_rq, w_odata;

  assign w_sc = (bus.stage > STG_W'(MSB)) ?
                STG_W'(MSB) : bus.stage;
  assign w_s  = (r_k == '0) ? w_sc : r_s;
  assign w_wperm = MSB'(fft_permute(
    MAXW'(r_k), int'(w_s), MSB));

`ifdef FFT_REORDER_PINGPONG_EN
  // Last sample of the old frame leaves as the new one starts.
  assign w_recycle = w_lastpop &&
                     (r_cbank == r_wbank);
  assign w_waddr   = {r_wbank, w_wperm};
  assign w_raddr   = {r_rbank, r_j};
`else
  assign w_recycle = 1'b0;
  assign w_waddr   = w_wperm;
  assign w_raddr   = r_j;
`endif

  assign w_wfree = (r_bst[r_wbank] == B_EMPTY) ||
                   (r_bst[r_wbank] == B_FILLING) ||
                   w_recycle;
  assign bus.in_ready = rst_n && w_wfree;
  assign w_wr = bus.in_valid && bus.in_ready;

  assign w_rok = (r_bst[r_rbank] == B_FULL) ||
                 (r_bst[r_rbank] == B_DRAINING &&
                  r_j != '0);
  // Skid occupancy after this cycle must leave room for the read.
  assign w_rd = w_rok &&
    (3'(r_cnt) + 3'(r_rvalid) <= 3'd1 + 3'(w_pop));

  assign w_ovalid = (r_cnt != 2'd0) || r_rvalid;
  assign w_pop    = w_ovalid && bus.out_ready;
  assign w_popq   = w_pop && (r_cnt != 2'd0);
  assign w_push   = r_rvalid &&
                    !(w_pop && r_cnt == 2'd0);
  assign w_oidx   = (r_cnt != 2'd0) ? r_qi[r_qr] :
                    r_rvalid ? r_ridx : '0;
  assign w_odata  = (r_cnt != 2'd0) ? r_qd[r_qr] :
                    r_rvalid ? w_rq : '0;
  assign w_lastpop = w_pop && (w_oidx == '1);

  assign bus.out_valid = w_ovalid;
  assign bus.out_data  = w_odata;
  assign bus.out_index = w_oidx;
  assign bus.out_last  = (w_oidx == '1);

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bst[b] = r_bst[b];
      if (w_rd && r_rbank == 1'(b) &&
          r_bst[b] == B_FULL)
        w_bst[b] = B_DRAINING;
      if (w_lastpop && r_cbank == 1'(b))
        w_bst[b] = B_EMPTY;
      if (w_wr && r_wbank == 1'(b))
        w_bst[b] = (r_k == '1) ? B_FULL : B_FILLING;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bst[0] <= B_EMPTY;
      r_bst[1] <= B_EMPTY;
      r_k      <= '0;
      r_j      <= '0;
      r_ridx   <= '0;
      r_s      <= '0;
      r_wbank  <= 1'b0;
      r_rbank  <= 1'b0;
      r_cbank  <= 1'b0;
      r_rvalid <= 1'b0;
      r_qd[0]  <= '0;
      r_qd[1]  <= '0;
      r_qi[0]  <= '0;
      r_qi[1]  <= '0;
      r_qr     <= 1'b0;
      r_qw     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      r_bst[0] <= w_bst[0];
      r_bst[1] <= w_bst[1];
      if (w_wr) begin
        r_k <= r_k + MSB'(1);
        if (r_k == '0)
          r_s <= w_sc;
        if (r_k == '1)
          r_wbank <= r_wbank ^ TOG;
      end
      if (w_rd) begin
        r_j    <= r_j + MSB'(1);
        r_ridx <= r_j;
        if (r_j == '1)
          r_rbank <= r_rbank ^ TOG;
      end
      r_rvalid <= w_rd;
      if (w_lastpop)
        r_cbank <= r_cbank ^ TOG;
      if (w_push) begin
        r_qd[r_qw] <= w_rq;
        r_qi[r_qw] <= r_ridx;
        r_qw       <= ~r_qw;
      end
      if (w_popq)
        r_qr <= ~r_qr;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_popq);
    end
  end

  fft_reorder_ram #(
    .DW (DATA_W),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (w_waddr),
    .i_wdata (bus.in_data),
    .i_re    (w_rd),
    .i_raddr (w_raddr),
    .o_rdata (w_rq)
  );

endmodule

// File: tb/tb_fft_output_reorder.sv
// tb_fft_output_reorder: random frames against a queue-based
// reference of the natural-order output stream (MSB=3, N=8).
module tb_fft_output_reorder;

  localparam int MSB = 3;
  localparam int N   = 8;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fft_output_reorder_if #(.MSB(MSB), .DATA_W(DW)) bus ();

  fft_output_reorder #(.MSB(MSB), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  logic          nrst, nv;
  logic [DW-1:0] nd;
  int            ns, rdy_pct, cyc;
  logic [DW-1:0] exp_d [$];
  int            exp_i [$];
  logic [DW-1:0] fr_buf [N];
  int            fr_cnt, fr_s, last_in_cyc;
  bit            fire, lat_arm, pp_watch;
  bit            prev_stall;
  logic [DW-1:0] prev_d;
  int            prev_i;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Natural index i holds the sample whose arrival index is
  // i with its top s bits mirrored.
  function automatic int ref_perm(input int i, input int s);
    int sc, lo_w, top, low, rev;
    sc   = (s > MSB) ? MSB : s;
    lo_w = MSB - sc;
    top  = i >> lo_w;
    low  = i % (1 << lo_w);
    rev  = 0;
    for (int b = 0; b < sc; b++)
      rev = rev * 2 + ((top >> b) & 1);
    return (rev << lo_w) + low;
  endfunction

  task automatic cycle();
    logic [DW-1:0] ed;
    int ei;
    @(negedge clk);
    rst_n         = nrst;
    bus.in_valid  = nv;
    bus.in_data   = nd;
    bus.stage     = ns[3:0];
    bus.out_ready = ($urandom_range(99) < rdy_pct);
    #1;
    cyc++;
    fire = 0;
    if (!nrst) begin
      fr_cnt = 0;
      exp_d.delete();
      exp_i.delete();
      prev_stall = 0;
      return;
    end
    if (bus.in_valid && bus.in_ready) begin
      fire = 1;
      if (fr_cnt == 0) fr_s = ns;
      fr_buf[fr_cnt] = nd;
      fr_cnt++;
      if (fr_cnt == N) begin
        for (int i = 0; i < N; i++) begin
          exp_d.push_back(fr_buf[ref_perm(i, fr_s)]);
          exp_i.push_back(i);
        end
        fr_cnt = 0;
        last_in_cyc = cyc;
      end
    end
    if (prev_stall) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, prev_d);
      check("hold_index", bus.out_index, prev_i);
    end
    if (lat_arm && bus.out_valid) begin
      check("latency", cyc - last_in_cyc, 2);
      check("lat_index", bus.out_index, 0);
      lat_arm = 0;
    end
    if (bus.out_valid && bus.out_ready) begin
      check("out_expected", exp_d.size() > 0, 1);
      if (exp_d.size() > 0) begin
        ed = exp_d.pop_front();
        ei = exp_i.pop_front();
        check("out_data", bus.out_data, ed);
        check("out_index", bus.out_index, ei);
        check("out_last", bus.out_last, ei == N - 1);
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_d = bus.out_data;
    prev_i = bus.out_index;
`ifdef FFT_REORDER_PINGPONG_EN
    if (pp_watch)
      check("pp_in_ready", bus.in_ready, 1);
`endif
  endtask

  task automatic send_frame(input int st, input int cnt,
                            input int vpct, input int base,
                            input bit rnd);
    int k, t;
    k = 0;
    t = 0;
    while (k < cnt && t < 500) begin
      nv = ($urandom_range(99) < vpct);
      nd = rnd ? DW'($urandom) : DW'(base + k);
      ns = st;
      cycle();
      if (fire) k++;
      t++;
    end
    if (k < cnt) check("in_timeout", k, cnt);
    nv = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    nv = 0;
    while (exp_d.size() != 0 && t < 300) begin
      cycle();
      t++;
    end
    check("drain", exp_d.size(), 0);
    repeat (4) cycle();
  endtask

  initial begin
    nrst = 0; nv = 0; nd = '0; ns = 0;
    rdy_pct = 100; cyc = 0; fr_cnt = 0; fr_s = 0;
    last_in_cyc = 0; lat_arm = 0; pp_watch = 0;
    prev_stall = 0; prev_d = '0; prev_i = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.stage = '0; bus.out_ready = 1'b0;

    repeat (3) cycle();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_index", bus.out_index, 0);
    check("rst_out_last", bus.out_last, 0);
    nrst = 1;
    cycle();
    check("in_ready_after_rst", bus.in_ready, 1);

    // Directed frames with in_data = 0..7.
    lat_arm = 1;
    send_frame(3, N, 100, 0, 0);
    drain();
    check("lat_seen", lat_arm, 0);
    send_frame(0, N, 100, 0, 0);
    drain();
    send_frame(2, N, 100, 0, 0);
    drain();
    send_frame(9, N, 100, 0, 0);
    drain();

    // Back-to-back frames with a stalling consumer.
    rdy_pct = 50;
    send_frame(3, N, 100, 0, 1);
    send_frame(0, N, 100, 0, 1);
    drain();

`ifdef FFT_REORDER_PINGPONG_EN
    rdy_pct = 100;
    pp_watch = 1;
    send_frame(3, N, 100, 0, 1);
    send_frame(0, N, 100, 0, 1);
    send_frame(2, N, 100, 0, 1);
    pp_watch = 0;
    drain();
`endif

    // Reset after a partial frame of five samples.
    rdy_pct = 100;
    send_frame(3, 5, 100, 32'h0dea_d000, 0);
    nrst = 0;
    cycle();
    check("mid_rst_in_ready", bus.in_ready, 0);
    nrst = 1;
    repeat (4) begin
      cycle();
      check("mid_rst_no_out", bus.out_valid, 0);
    end
    send_frame(3, N, 100, 100, 0);
    drain();

    // Random stages (some above MSB), random traffic.
    rdy_pct = 50;
    for (int f = 0; f < 6; f++)
      send_frame($urandom_range(15), N, 70, 0, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
